// File: rtl/mac_unit_vert_bitserial_seq.sv
// Bit-serial vertical MAC: latches one activation vector, then takes
// WEIGHT_BITS weight bit-columns (MSB first) over col_valid/col_ready.
// Ports: start/in_ready accept an op (act_in, mode, result_prev latched);
// act_sel/sum_act/is_skip_zero describe each column; result/out_valid/out_ready
// return the saturated result. Macro MAC_UNIT_POOLING_EN enables mode 10 max-pool.
module mac_unit_vert_bitserial_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 16,
  parameter int GROUP_SIZE    = 8,
  parameter int SEL_PER_GROUP = 4,
  parameter int WEIGHT_BITS   = 8,
  parameter int RESULT_WIDTH  = 2*DATA_WIDTH,
  parameter int OUT_SHIFT     = 0,
  localparam int NGROUPS   = VEC_LENGTH/GROUP_SIZE,
  localparam int SEL_W     = $clog2(GROUP_SIZE+1),
  localparam int SUM_W     = DATA_WIDTH+$clog2(GROUP_SIZE),
  localparam int ACC_WIDTH = DATA_WIDTH+WEIGHT_BITS+$clog2(VEC_LENGTH)+1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   in_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]       act_in,
  input  logic [1:0]                             mode,
  input  logic [RESULT_WIDTH-1:0]                result_prev,
  input  logic                                   col_valid,
  output logic                                   col_ready,
  input  logic [NGROUPS*SEL_PER_GROUP*SEL_W-1:0] act_sel,
  input  logic [NGROUPS*SUM_W-1:0]               sum_act,
  input  logic [NGROUPS-1:0]                     is_skip_zero,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RESULT_WIDTH-1:0]                result
);

  localparam int CNT_W = (WEIGHT_BITS > 1) ? $clog2(WEIGHT_BITS) : 1;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    (ACC_WIDTH+1)'((2**(RESULT_WIDTH-1))-1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, FINAL, DONE
  } state_t;

  state_t                          state_q;
  logic [CNT_W-1:0]                col_cnt_q;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] act_q;
  logic [1:0]                      mode_q;
  logic signed [RESULT_WIDTH-1:0]  prev_q;
  logic signed [ACC_WIDTH-1:0]     psum_q, psum_d;
  logic                            psum_vld_q;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [RESULT_WIDTH-1:0]         result_q, result_d;
  logic                            out_valid_q;
  logic                            col_ready_q;
  logic                            in_ready_q;

  logic                            beat;
  logic                            last_col;
  logic signed [ACC_WIDTH-1:0]     grp_sel, grp_psum, col_sum;
  logic signed [ACC_WIDTH-1:0]     acc_sh;
  logic signed [ACC_WIDTH:0]       fin_sum;
  logic signed [RESULT_WIDTH-1:0]  sat_val;

  assign beat     = col_valid & col_ready_q;
  assign last_col = (col_cnt_q == CNT_W'(WEIGHT_BITS-1));

  // Column partial sum; the MSB column carries negative weight.
  always_comb begin
    col_sum  = '0;
    grp_sel  = '0;
    grp_psum = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      grp_sel = '0;
      for (int s = 0; s < SEL_PER_GROUP; s++) begin
        for (int l = 0; l < GROUP_SIZE; l++) begin
          if (act_sel[(g*SEL_PER_GROUP+s)*SEL_W +: SEL_W] == SEL_W'(l))
            grp_sel = grp_sel + ACC_WIDTH'($signed(
              act_q[(g*GROUP_SIZE+l)*DATA_WIDTH +: DATA_WIDTH]));
        end
      end
      if (is_skip_zero[g])
        grp_psum = grp_sel;
      else
        grp_psum = ACC_WIDTH'($signed(sum_act[g*SUM_W +: SUM_W])) - grp_sel;
      col_sum = col_sum + grp_psum;
    end
    psum_d = (col_cnt_q == '0) ? -col_sum : col_sum;
  end

  assign acc_d = (acc_q <<< 1) + psum_q;

  always_comb begin
    acc_sh  = acc_q >>> OUT_SHIFT;
    fin_sum = (ACC_WIDTH+1)'(acc_sh);
    if (mode_q == 2'b01)
      fin_sum = fin_sum + (ACC_WIDTH+1)'(prev_q);
    if (fin_sum > SAT_MAX)
      sat_val = SAT_MAX[RESULT_WIDTH-1:0];
    else if (fin_sum < SAT_MIN)
      sat_val = SAT_MIN[RESULT_WIDTH-1:0];
    else
      sat_val = fin_sum[RESULT_WIDTH-1:0];
    result_d = sat_val;
`ifdef MAC_UNIT_POOLING_EN
    if (mode_q == 2'b10 && sat_val < prev_q)
      result_d = prev_q;
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      act_q       <= '0;
      mode_q      <= '0;
      prev_q      <= '0;
      psum_q      <= '0;
      psum_vld_q  <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      col_ready_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      psum_vld_q <= beat;
      if (beat)
        psum_q <= psum_d;
      if (psum_vld_q)
        acc_q <= acc_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            act_q       <= act_in;
            mode_q      <= mode;
            prev_q      <= result_prev;
            acc_q       <= '0;
            col_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            col_ready_q <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            col_cnt_q <= col_cnt_q + CNT_W'(1);
            if (last_col) begin
              col_ready_q <= 1'b0;
              state_q     <= DRAIN;
            end
          end
        end
        DRAIN: state_q <= FINAL;
        FINAL: begin
          result_q    <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign col_ready = col_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mac_unit_vert_bitserial_seq.sv
// Self-checking bench for mac_unit_vert_bitserial_seq: a dot-product model
// derives expected results; columns are generated from integer weights.
module tb_mac_unit_vert_bitserial_seq;
  localparam int DW = 8, VL = 16, GS = 8, SPG = 4, WB = 8, RW = 16;
  localparam int NG = 2, SW = 4, SUMW = 11;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic col_valid = 1'b0, out_ready = 1'b0;
  logic [VL*DW-1:0] act_in = '0;
  logic [1:0] mode = '0;
  logic [RW-1:0] result_prev = '0;
  logic [NG*SPG*SW-1:0] act_sel = '0;
  logic [NG*SUMW-1:0] sum_act = '0;
  logic [NG-1:0] is_skip_zero = '0;
  logic in_ready, col_ready, out_valid;
  logic signed [RW-1:0] result;

  int checks = 0, errors = 0;
  int exp_result = 0;
  int cur_act[VL];
  int cur_w[VL];

  mac_unit_vert_bitserial_seq dut (
    .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
    .act_in(act_in), .mode(mode), .result_prev(result_prev),
    .col_valid(col_valid), .col_ready(col_ready), .act_sel(act_sel),
    .sum_act(sum_act), .is_skip_zero(is_skip_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk)
    if (!reset && out_valid)
      check("result", int'(result), exp_result);

  function automatic int model(input int m, input int prev);
    longint d = 0;
    for (int k = 0; k < VL; k++) d += longint'(cur_act[k] * cur_w[k]);
    if (m == 1) d += prev;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
`ifdef MAC_UNIT_POOLING_EN
    if (m == 2 && prev > d) d = prev;
`endif
    return int'(d);
  endfunction

  // Build column j (j=0 is the weight MSB) from the integer weights.
  task automatic set_col(input int j);
    int b, ones, slot, gsum;
    logic skip;
    b = WB - 1 - j;
    for (int g = 0; g < NG; g++) begin
      ones = 0; slot = 0; gsum = 0;
      for (int l = 0; l < GS; l++)
        if (((cur_w[g*GS+l] >> b) & 1) == 1) ones++;
      skip = (ones <= SPG);
      for (int s = 0; s < SPG; s++) act_sel[(g*SPG+s)*SW +: SW] = 4'd8;
      for (int l = 0; l < GS; l++) begin
        gsum += cur_act[g*GS+l];
        if ((((cur_w[g*GS+l] >> b) & 1) == 1) == skip) begin
          act_sel[(g*SPG+slot)*SW +: SW] = SW'(l);
          slot++;
        end
      end
      sum_act[g*SUMW +: SUMW] = SUMW'(gsum);
      is_skip_zero[g] = skip;
    end
  endtask

  task automatic set_garbage();
    act_sel = '0;
    is_skip_zero = '0;
    for (int g = 0; g < NG; g++) sum_act[g*SUMW +: SUMW] = SUMW'(300);
  endtask

  task automatic load(input int a_all, input int w_all);
    for (int k = 0; k < VL; k++) begin
      cur_act[k] = a_all;
      cur_w[k] = w_all;
    end
  endtask

  task automatic load_s2();
    load(0, 0);
    cur_act[0] = 5;
    cur_w[0] = 3;
  endtask

  task automatic accept(input int m, input int prev);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    for (int k = 0; k < VL; k++) act_in[k*DW +: DW] = DW'(cur_act[k]);
    mode = 2'(m);
    result_prev = RW'(prev);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    act_in = '1;
    result_prev = '0;
    mode = 2'b11;
  endtask

  task automatic run_op(input string tag, input int m, input int prev,
                        input int gap_after, input int gap_len,
                        input int hold, input int lit);
    int n;
    exp_result = model(m, prev);
    check({tag, "_model"}, exp_result, lit);
    out_ready = (hold == 0);
    accept(m, prev);
    check({tag, "_acc_in_ready"}, int'(in_ready), 0);
    check({tag, "_acc_col_ready"}, int'(col_ready), 1);
    n = 0;
    for (int j = 0; j < WB; j++) begin
      set_col(j);
      col_valid = 1'b1;
      @(posedge clk); #1; n++;
      if (j == gap_after) begin
        col_valid = 1'b0;
        set_garbage();
        start = 1'b1;
        for (int q = 0; q < gap_len; q++) begin
          @(posedge clk); #1; n++;
          check({tag, "_gap_in_ready"}, int'(in_ready), 0);
          check({tag, "_gap_col_ready"}, int'(col_ready), 1);
        end
        start = 1'b0;
      end
    end
    set_garbage();
    col_valid = 1'b1;
    check({tag, "_drain_col_ready"}, int'(col_ready), 0);
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, n, WB + 2 + gap_len);
    if (hold > 0) begin
      start = 1'b1;
      for (int q = 0; q < hold; q++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, int'(out_valid), 1);
        check({tag, "_hold_in_ready"}, int'(in_ready), 0);
        check({tag, "_hold_col_ready"}, int'(col_ready), 0);
      end
      start = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_done_valid"}, int'(out_valid), 0);
    check({tag, "_done_in_ready"}, int'(in_ready), 1);
    out_ready = 1'b0;
    col_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_col_ready", int'(col_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    load(1, -1);
    run_op("s1", 0, 0, -1, 0, 0, -16);
    load_s2();
    run_op("s2", 0, 0, -1, 0, 0, 15);
    load(1, -1);
    run_op("s3a", 1, 100, -1, 0, 0, 84);
    run_op("s3b", 1, -32768, -1, 0, 0, -32768);
    run_op("m11", 3, 0, -1, 0, 0, -16);
    load(127, -128);
    run_op("s4a", 0, 0, -1, 0, 0, -32768);
    load(-128, -128);
    run_op("s4b", 0, 0, -1, 0, 0, 32767);
    for (int k = 0; k < VL; k++) begin
      cur_act[k] = k - 8;
      cur_w[k] = (k % 2 == 0) ? 3 : -2;
    end
    run_op("mix", 0, 0, -1, 0, 0, -24);
    run_op("mix01", 1, 30, -1, 0, 0, 6);
    load_s2();
    run_op("s5", 0, 0, 3, 3, 5, 15);

    load(3, 7);
    accept(0, 0);
    for (int j = 0; j < 4; j++) begin
      set_col(j);
      col_valid = 1'b1;
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_col_ready", int'(col_ready), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_result", int'(result), 0);
    col_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    load_s2();
    run_op("s6", 0, 0, -1, 0, 0, 15);
`ifdef MAC_UNIT_POOLING_EN
    run_op("pool50", 2, 50, -1, 0, 0, 50);
    run_op("pool_m7", 2, -7, -1, 0, 0, 15);
`else
    run_op("nopool50", 2, 50, -1, 0, 0, 15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
